// File: rtl/cpu_clk_en_ctrl.sv
// cpu_clk_en_ctrl: run-mode scheduler for the CPU core.
// Produces a single-cycle clock enable in the ui_clk domain instead of a
// derived clock. Modes: MANUAL step, SLOW, FAST, FULL. Every mode change goes
// through a halt handshake so the core is never switched mid-instruction.
// Optional build macro: CLK_CTRL_ACK_TIMEOUT_EN adds a halt-ack timeout that
// forces the switch and raises the sticky ack_timeout flag.
module cpu_clk_en_ctrl #(
  parameter int SLOW_DIV_W = 22,
  parameter int FAST_DIV_W = 2,
  parameter int DEBOUNCE_W = 16
`ifdef CLK_CTRL_ACK_TIMEOUT_EN
  ,
  parameter int ACK_TO_W   = 8
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode_sel,
  input  logic        manual_btn,
  input  logic        halt_ack,
  output logic        halt_req,
  output logic        cpu_clk_en,
  output logic [1:0]  mode_cur,
  output logic [31:0] en_count,
  output logic        ack_timeout
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;

  localparam logic [1:0] M_MANUAL = 2'b00;
  localparam logic [1:0] M_SLOW   = 2'b01;
  localparam logic [1:0] M_FAST   = 2'b10;

  logic [1:0]            mode_s1, mode_s2;
  logic                  btn_s1, btn_s2;
  logic [DEBOUNCE_W-1:0] deb_cnt;
  logic                  btn_stable;
  logic                  btn_rise;
  logic [1:0]            state;
  logic [SLOW_DIV_W-1:0] div_cnt;
  logic                  step_flag;
`ifdef CLK_CTRL_ACK_TIMEOUT_EN
  logic [ACK_TO_W-1:0]   to_cnt;
`endif

  // Two-flop synchronisers for the asynchronous switches and button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1 <= '0;
      mode_s2 <= '0;
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
    end else begin
      mode_s1 <= mode_sel;
      mode_s2 <= mode_s1;
      btn_s1  <= manual_btn;
      btn_s2  <= btn_s1;
    end
  end

  // Debounce: count while the synced button disagrees with btn_stable; any
  // agreement (a bounce back) restarts the count. Only a disagreement that
  // survives until the counter is all-ones is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt    <= '0;
      btn_stable <= 1'b0;
    end else if (btn_s2 == btn_stable) begin
      deb_cnt <= '0;
    end else if (&deb_cnt) begin
      deb_cnt    <= '0;
      btn_stable <= btn_s2;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // 0->1 transition of btn_stable, seen the cycle it is committed
  assign btn_rise = btn_s2 && !btn_stable && (&deb_cnt);

  // Mode FSM, enable generation and halt handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      mode_cur    <= M_MANUAL;
      div_cnt     <= '0;
      step_flag   <= 1'b0;
      cpu_clk_en  <= 1'b0;
      halt_req    <= 1'b0;
`ifdef CLK_CTRL_ACK_TIMEOUT_EN
      to_cnt      <= '0;
      ack_timeout <= 1'b0;
`endif
    end else begin
      case (state)
        ST_RUN: begin
          if (mode_s2 != mode_cur) begin
            // Mode change wins over enable generation: stop the core first
            state      <= ST_DRAIN;
            halt_req   <= 1'b1;
            cpu_clk_en <= 1'b0;
`ifdef CLK_CTRL_ACK_TIMEOUT_EN
            to_cnt     <= '0;
`endif
          end else begin
            div_cnt <= div_cnt + 1'b1;
            case (mode_cur)
              M_MANUAL: begin
                cpu_clk_en <= step_flag;
                step_flag  <= 1'b0;
              end
              M_SLOW:  cpu_clk_en <= &div_cnt;
              M_FAST:  cpu_clk_en <= &div_cnt[FAST_DIV_W-1:0];
              default: cpu_clk_en <= 1'b1;
            endcase
            // A fresh press outranks consuming the previous one
            if (btn_rise && (mode_cur == M_MANUAL)) step_flag <= 1'b1;
          end
        end
        ST_DRAIN: begin
          cpu_clk_en <= 1'b0;
          if (halt_ack) state <= ST_SWITCH;
`ifdef CLK_CTRL_ACK_TIMEOUT_EN
          else if (&to_cnt) begin
            state       <= ST_SWITCH;
            ack_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        ST_SWITCH: begin
          // Latest synced selection wins; equal to mode_cur is a no-op
          mode_cur   <= mode_s2;
          div_cnt    <= '0;
          step_flag  <= 1'b0;
          halt_req   <= 1'b0;
          cpu_clk_en <= 1'b0;
          state      <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifndef CLK_CTRL_ACK_TIMEOUT_EN
  assign ack_timeout = 1'b0;
`endif

  // Running count of enabled cycles, wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          en_count <= '0;
    else if (cpu_clk_en) en_count <= en_count + 32'd1;
  end

endmodule

// File: tb/tb_cpu_clk_en_ctrl.sv
// Bench for cpu_clk_en_ctrl: table of mode switches with a cpu_clk_en
// scoreboard, plus hand sequences for debounce, DRAIN retargeting, ack
// timeout (CLK_CTRL_ACK_TIMEOUT_EN) and asynchronous reset.
module tb_cpu_clk_en_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode_sel = 2'b00;
  logic        manual_btn = 1'b0;
  logic        halt_ack = 1'b0;
  logic        halt_req, cpu_clk_en, ack_timeout;
  logic [1:0]  mode_cur;
  logic [31:0] en_count;

  int n_checks = 0;
  int n_errors = 0;
  logic exp_q[$];

  typedef struct {
    logic [1:0] mode;
    int         ack_dly;     // -1: ack already high before DRAIN
    int         run_cyc;
    int         exp_pulses;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  cpu_clk_en_ctrl #(
    .SLOW_DIV_W(5),
    .FAST_DIV_W(2),
    .DEBOUNCE_W(4)
`ifdef CLK_CTRL_ACK_TIMEOUT_EN
    ,
    .ACK_TO_W(3)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode_sel(mode_sel), .manual_btn(manual_btn),
    .halt_ack(halt_ack), .halt_req(halt_req), .cpu_clk_en(cpu_clk_en),
    .mode_cur(mode_cur), .en_count(en_count), .ack_timeout(ack_timeout)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference enable for RUN cycle k (k=0 is the first cycle after SWITCH)
  function automatic logic exp_en(input logic [1:0] m, input int k);
    case (m)
      2'b00:   return 1'b0;
      2'b01:   return (k % 32) == 0;
      2'b10:   return (k % 4) == 0;
      default: return 1'b1;
    endcase
  endfunction

  // Switch modes; returns at negedge+1 of the first RUN cycle
  task automatic do_switch(input logic [1:0] m, input int ack_dly);
    int hi;
    bit seen;
    @(negedge clk); #1;
    mode_sel = m;
    if (ack_dly < 0) halt_ack = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (halt_req) seen = 1;
    end
    chk("drain_entry", 32'(seen), 32'd1);
    hi = 1;
    chk("drain_en0", 32'(cpu_clk_en), 32'd0);
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      chk("drain_en", 32'(cpu_clk_en), 32'd0);
      if (halt_req) hi++;
    end
    #1 halt_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!halt_req) break;
      hi++;
      if (cpu_clk_en) chk("switch_en", 32'(cpu_clk_en), 32'd0);
    end
    chk("halt_cycles", 32'(hi), (ack_dly < 0) ? 32'd2 : 32'(ack_dly + 2));
    chk("mode_cur", 32'(mode_cur), 32'(m));
    chk("run0_en", 32'(cpu_clk_en), 32'd0);
    #1 halt_ack = 1'b0;
  endtask

  // Push expected enables for RUN cycles 1..n and wait for the scoreboard
  task automatic run_pattern(input logic [1:0] m, input int n, input int exp_pulses);
    int pulses = 0;
    int hr = 0;
    for (int k = 1; k <= n; k++) exp_q.push_back(exp_en(m, k));
    for (int i = 0; i < n + 5; i++) begin
      @(negedge clk); #1;
      if (cpu_clk_en) pulses++;
      if (halt_req) hr++;
      if (exp_q.size() == 0) break;
    end
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("pulse_count", 32'(pulses), 32'(exp_pulses));
    chk("no_resw", 32'(hr), 32'd0);
  endtask

  task automatic count_pulses(input int n, output int p);
    p = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cpu_clk_en) p++;
    end
  endtask

  initial begin
    int p, hi, stuck;
    bit seen;
    vecs[0] = '{2'b10, 3, 22, 5};
    vecs[1] = '{2'b11, 0, 10, 10};
    vecs[2] = '{2'b01, -1, 70, 2};
    vecs[3] = '{2'b00, 1, 10, 0};
    vecs[4] = '{2'b11, 2, 8, 8};

    // Scoreboard consumer: one expected enable per negedge
    fork
      forever begin
        @(negedge clk);
        if (exp_q.size() > 0) begin
          logic e;
          e = exp_q.pop_front();
          chk("sb_en", 32'(cpu_clk_en), 32'(e));
        end
      end
    join_none

    // Reset state
    @(negedge clk);
    chk("rst_halt_req", 32'(halt_req), 32'd0);
    chk("rst_en", 32'(cpu_clk_en), 32'd0);
    chk("rst_mode", 32'(mode_cur), 32'd0);
    chk("rst_cnt", en_count, 32'd0);
    chk("rst_to", 32'(ack_timeout), 32'd0);
    #1 rst_n = 1'b1;

    // Table of mode switches
    foreach (vecs[i]) begin
      do_switch(vecs[i].mode, vecs[i].ack_dly);
      run_pattern(vecs[i].mode, vecs[i].run_cyc, vecs[i].exp_pulses);
      if (i == 0) chk("fast_en_count", en_count, 32'd5);
    end

    // FULL -> 01 -> 10 while draining, ack low for 6 cycles: one switch to FAST
    @(negedge clk); #1 mode_sel = 2'b01;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (halt_req) seen = 1;
    end
    chk("t4_drain", 32'(seen), 32'd1);
    hi = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) #1 mode_sel = 2'b10;
      @(negedge clk);
      if (halt_req) hi++;
    end
    #1 halt_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!halt_req) break;
      hi++;
    end
    chk("t4_halt_cycles", 32'(hi), 32'd8);
    chk("t4_mode", 32'(mode_cur), 32'b10);
    #1 halt_ack = 1'b0;
    run_pattern(2'b10, 12, 3);

    // Debounce in MANUAL
    do_switch(2'b00, 0);
    #1 manual_btn = 1'b1;
    repeat (3) @(negedge clk);
    #1 manual_btn = 1'b0;
    count_pulses(40, p);  chk("deb_glitch", 32'(p), 32'd0);
    #1 manual_btn = 1'b1;
    count_pulses(40, p);  chk("deb_press1", 32'(p), 32'd1);
    count_pulses(1000, p); chk("deb_hold", 32'(p), 32'd0);
    #1 manual_btn = 1'b0;
    count_pulses(40, p);  chk("deb_release", 32'(p), 32'd0);
    #1 manual_btn = 1'b1;
    count_pulses(40, p);  chk("deb_press2", 32'(p), 32'd1);
    #1 manual_btn = 1'b0;
    count_pulses(40, p);

    // Halt-ack never arrives
    @(negedge clk); #1 mode_sel = 2'b11;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (halt_req) seen = 1;
    end
    chk("t5_drain", 32'(seen), 32'd1);
`ifdef CLK_CTRL_ACK_TIMEOUT_EN
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!halt_req) break;
      hi++;
    end
    chk("to_halt_cycles", 32'(hi), 32'd9);
    chk("to_flag", 32'(ack_timeout), 32'd1);
    chk("to_mode", 32'(mode_cur), 32'b11);
    do_switch(2'b10, 1);
    chk("to_sticky", 32'(ack_timeout), 32'd1);
`else
    stuck = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (halt_req && !cpu_clk_en && mode_cur == 2'b00) stuck++;
    end
    chk("no_to_stuck", 32'(stuck), 32'd1000);
    chk("no_to_flag", 32'(ack_timeout), 32'd0);
    #1 halt_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!halt_req) break;
    end
    chk("no_to_mode", 32'(mode_cur), 32'b11);
    #1 halt_ack = 1'b0;
    do_switch(2'b10, 1);
`endif

    // Asynchronous reset mid-run in FULL
    do_switch(2'b11, 2);
    run_pattern(2'b11, 6, 6);
    @(posedge clk); #2;
    rst_n = 1'b0;
    mode_sel = 2'b00;
    #1;
    chk("arst_en", 32'(cpu_clk_en), 32'd0);
    chk("arst_halt_req", 32'(halt_req), 32'd0);
    chk("arst_cnt", en_count, 32'd0);
    chk("arst_mode", 32'(mode_cur), 32'd0);
    chk("arst_to", 32'(ack_timeout), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    stuck = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cpu_clk_en || halt_req) stuck++;
    end
    chk("post_rst_idle", 32'(stuck), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
